// File: rtl/time_set_ctrl.sv
// Time-set control: 1 Hz tick divider, cascade count enables and the button-driven
// set-time FSM feeding the BCD counter chain. Optional blink toggle via TIME_SET_BLINK_EN.
module time_set_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int DIV_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pulse,
  input  logic       inc_pulse,
  input  logic [3:0] cur_sec0,
  input  logic [3:0] cur_sec1,
  input  logic [3:0] cur_min0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_hour1,
  output logic [2:0] count_enable,
  output logic       load_value_enable,
  output logic [3:0] load_value_sec0,
  output logic [3:0] load_value_sec1,
  output logic [3:0] load_value_min0,
  output logic [3:0] load_value_min1,
  output logic [3:0] load_value_hour0,
  output logic [3:0] load_value_hour1,
  output logic [1:0] edit_field,
  output logic       blink
);

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    LOAD
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             sec_max;
  logic             min_max;

  // Free-running divider; the tick is registered so it lands one cycle after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign sec_max = (cur_sec1 == 4'd5) && (cur_sec0 == 4'd9);
  assign min_max = (cur_min1 == 4'd5) && (cur_min0 == 4'd9);

  always_comb begin
    count_enable = 3'b000;
    if (state == RUN) begin
      count_enable = {tick & sec_max & min_max, tick & sec_max, tick};
    end
  end

  // Minutes/seconds: 59 wraps to 00; out-of-range digits wrap to 0 instead of propagating garbage.
  function automatic logic [7:0] inc_base60(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    if (ones >= 4'd9) begin
      o = 4'd0;
      t = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
    end else begin
      o = ones + 4'd1;
      t = tens;
    end
    return {t, o};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    if ((tens >= 4'd2) && (ones >= 4'd3)) begin
      t = 4'd0;
      o = 4'd0;
    end else if (ones >= 4'd9) begin
      t = tens + 4'd1;
      o = 4'd0;
    end else begin
      t = tens;
      o = ones + 4'd1;
    end
    return {t, o};
  endfunction

`ifdef TIME_SET_BLINK_EN
  logic blink_q;
  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

  // Set-time FSM; mode_pulse has priority over inc_pulse so a simultaneous press never edits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= RUN;
      load_value_enable <= 1'b0;
      edit_field        <= 2'd0;
      load_value_sec0   <= 4'd0;
      load_value_sec1   <= 4'd0;
      load_value_min0   <= 4'd0;
      load_value_min1   <= 4'd0;
      load_value_hour0  <= 4'd0;
      load_value_hour1  <= 4'd0;
`ifdef TIME_SET_BLINK_EN
      blink_q           <= 1'b0;
`endif
    end else begin
      load_value_enable <= 1'b0;
      case (state)
        RUN: begin
          if (mode_pulse) begin
            state            <= SET_HOUR;
            edit_field       <= 2'd1;
            load_value_sec0  <= cur_sec0;
            load_value_sec1  <= cur_sec1;
            load_value_min0  <= cur_min0;
            load_value_min1  <= cur_min1;
            load_value_hour0 <= cur_hour0;
            load_value_hour1 <= cur_hour1;
          end
        end
        SET_HOUR: begin
          if (mode_pulse) begin
            state      <= SET_MIN;
            edit_field <= 2'd2;
          end else if (inc_pulse) begin
            {load_value_hour1, load_value_hour0} <= inc_hour(load_value_hour1, load_value_hour0);
          end
        end
        SET_MIN: begin
          if (mode_pulse) begin
            state      <= SET_SEC;
            edit_field <= 2'd3;
          end else if (inc_pulse) begin
            {load_value_min1, load_value_min0} <= inc_base60(load_value_min1, load_value_min0);
          end
        end
        SET_SEC: begin
          if (mode_pulse) begin
            state             <= LOAD;
            edit_field        <= 2'd0;
            load_value_enable <= 1'b1;
          end else if (inc_pulse) begin
            {load_value_sec1, load_value_sec0} <= inc_base60(load_value_sec1, load_value_sec0);
          end
        end
        LOAD: begin
          state      <= RUN;
          edit_field <= 2'd0;
        end
        default: begin
          state      <= RUN;
          edit_field <= 2'd0;
        end
      endcase
`ifdef TIME_SET_BLINK_EN
      // Entering any set state restarts the blink phase visibly on.
      if (mode_pulse && (state inside {RUN, SET_HOUR, SET_MIN})) begin
        blink_q <= 1'b1;
      end else if (!mode_pulse && (state inside {SET_HOUR, SET_MIN, SET_SEC})) begin
        if (tick) begin
          blink_q <= ~blink_q;
        end
      end else begin
        blink_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with TICK_DIV=4: a time/mode model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_time_set_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_pulse = 1'b0;
  logic       inc_pulse = 1'b0;
  logic [3:0] cur_sec0 = 4'd0, cur_sec1 = 4'd0, cur_min0 = 4'd0;
  logic [3:0] cur_min1 = 4'd0, cur_hour0 = 4'd0, cur_hour1 = 4'd0;
  logic [2:0] count_enable;
  logic       load_value_enable;
  logic [3:0] load_value_sec0, load_value_sec1, load_value_min0;
  logic [3:0] load_value_min1, load_value_hour0, load_value_hour1;
  logic [1:0] edit_field;
  logic       blink;

  int checks = 0;
  int failures = 0;

  time_set_ctrl #(.TICK_DIV(TD), .DIV_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .mode_pulse(mode_pulse), .inc_pulse(inc_pulse),
    .cur_sec0(cur_sec0), .cur_sec1(cur_sec1), .cur_min0(cur_min0),
    .cur_min1(cur_min1), .cur_hour0(cur_hour0), .cur_hour1(cur_hour1),
    .count_enable(count_enable), .load_value_enable(load_value_enable),
    .load_value_sec0(load_value_sec0), .load_value_sec1(load_value_sec1),
    .load_value_min0(load_value_min0), .load_value_min1(load_value_min1),
    .load_value_hour0(load_value_hour0), .load_value_hour1(load_value_hour1),
    .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  // Model: cycles since reset release, mode 0=run 1..3=set hour/min/sec 4=load, time as integers.
  int   m_cyc, m_mode, m_h, m_m, m_s, prev_mode;
  logic m_blink, prev_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_blink = 1'b0;
    end else begin
      prev_tick = (m_cyc > 0) && (m_cyc % TD == 0);
      prev_mode = m_mode;
      if (m_mode == 4) begin
        m_mode = 0;
      end else if (mode_pulse) begin
        if (m_mode == 0) begin
          m_h = int'(cur_hour1) * 10 + int'(cur_hour0);
          m_m = int'(cur_min1) * 10 + int'(cur_min0);
          m_s = int'(cur_sec1) * 10 + int'(cur_sec0);
        end
        m_mode = m_mode + 1;
      end else if (inc_pulse) begin
        case (m_mode)
          1: m_h = (m_h >= 23) ? 0 : m_h + 1;
          2: m_m = (m_m >= 59) ? 0 : m_m + 1;
          3: m_s = (m_s >= 59) ? 0 : m_s + 1;
          default: ;
        endcase
      end
      m_cyc = m_cyc + 1;
      if (m_mode >= 1 && m_mode <= 3) begin
        if (m_mode != prev_mode) m_blink = 1'b1;
        else if (prev_tick) m_blink = ~m_blink;
      end else begin
        m_blink = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] lvPacked();
    return {load_value_hour1, load_value_hour0, load_value_min1,
            load_value_min0, load_value_sec1, load_value_sec0};
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic       exp_tick, s59, m59;
    logic [2:0] exp_ce;
    logic       exp_blink;
    exp_tick = rst_n && (m_cyc > 0) && (m_cyc % TD == 0);
    s59 = (cur_sec1 == 4'd5) && (cur_sec0 == 4'd9);
    m59 = (cur_min1 == 4'd5) && (cur_min0 == 4'd9);
    exp_ce = (m_mode == 0 && exp_tick) ? {s59 && m59, s59, 1'b1} : 3'b000;
`ifdef TIME_SET_BLINK_EN
    exp_blink = m_blink;
`else
    exp_blink = 1'b0;
`endif
    checkOutput("model_count_enable", 32'(count_enable), 32'(exp_ce));
    checkOutput("model_load_enable", 32'(load_value_enable), 32'(m_mode == 4));
    checkOutput("model_edit_field", 32'(edit_field),
                (m_mode >= 1 && m_mode <= 3) ? 32'(m_mode) : 32'd0);
    checkOutput("model_load_value", 32'(lvPacked()),
                32'({4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
                     4'(m_s / 10), 4'(m_s % 10)}));
    checkOutput("model_blink", 32'(blink), 32'(exp_blink));
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic i);
    mode_pulse = m;
    inc_pulse  = i;
    nextCycle();
    mode_pulse = 1'b0;
    inc_pulse  = 1'b0;
  endtask

  task automatic setCur(input logic [3:0] h1, h0, m1, m0, s1, s0);
    cur_hour1 = h1; cur_hour0 = h0; cur_min1 = m1;
    cur_min0 = m0; cur_sec1 = s1; cur_sec0 = s0;
  endtask

  task automatic waitTick(input string name, input logic [2:0] exp);
    int n;
    n = 0;
    nextCycle();
    while (count_enable == 3'b000 && n < 8) begin
      nextCycle();
      n++;
    end
    if (n >= 8) begin
      failures++;
      $display("[TB] FAIL %s_timeout: no tick within 8 cycles", name);
    end
    checkOutput(name, 32'(count_enable), 32'(exp));
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: bench did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset state
    nextCycle();
    nextCycle();
    checkOutput("reset_ce", 32'(count_enable), 32'd0);
    checkOutput("reset_load_en", 32'(load_value_enable), 32'd0);
    checkOutput("reset_edit_field", 32'(edit_field), 32'd0);
    checkOutput("reset_load_value", 32'(lvPacked()), 32'd0);
    checkOutput("reset_blink", 32'(blink), 32'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      nextCycle();
      checkOutput($sformatf("free_ce_c%0d", c), 32'(count_enable),
                  (c % 4 == 0) ? 32'd1 : 32'd0);
    end

    // Cascade enables at a tick
    setCur(4'd1, 4'd2, 4'd5, 4'd9, 4'd5, 4'd9);
    waitTick("cascade_125959", 3'b111);
    setCur(4'd1, 4'd2, 4'd5, 4'd8, 4'd5, 4'd9);
    waitTick("cascade_125859", 3'b011);
    setCur(4'd1, 4'd2, 4'd5, 4'd8, 4'd5, 4'd8);
    waitTick("cascade_125858", 3'b001);

    // Capture and hour wrap
    setCur(4'd0, 4'd9, 4'd1, 4'd5, 4'd3, 4'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("capture_field", 32'(edit_field), 32'd1);
    checkOutput("capture_value", 32'(lvPacked()), 32'h091530);
    setCur(4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4);
    repeat (15) applyStimulus(1'b0, 1'b1);
    checkOutput("hour_wrap_00", 32'(lvPacked()), 32'h001530);
    repeat (3) applyStimulus(1'b0, 1'b1);
    checkOutput("hour_03", 32'(lvPacked()), 32'h031530);
    applyStimulus(1'b1, 1'b0);
    checkOutput("field_min", 32'(edit_field), 32'd2);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("load_strobe_a", 32'(load_value_enable), 32'd1);
    checkOutput("load_value_a", 32'(lvPacked()), 32'h031530);
    nextCycle();
    checkOutput("load_done_a", 32'(load_value_enable), 32'd0);

    // Full edit pass: two minute increments
    setCur(4'd0, 4'd9, 4'd1, 4'd5, 4'd3, 4'd0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("field_sec", 32'(edit_field), 32'd3);
    applyStimulus(1'b1, 1'b0);
    checkOutput("load_strobe_b", 32'(load_value_enable), 32'd1);
    checkOutput("load_value_b", 32'(lvPacked()), 32'h091730);
    nextCycle();
    checkOutput("load_done_b", 32'(load_value_enable), 32'd0);
    checkOutput("run_field_b", 32'(edit_field), 32'd0);

    // Mode and inc together: mode wins
    setCur(4'd0, 4'd0, 4'd5, 4'd9, 4'd1, 4'd0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("collide_field", 32'(edit_field), 32'd3);
    checkOutput("collide_value", 32'(lvPacked()), 32'h005910);
    applyStimulus(1'b0, 1'b1);
    checkOutput("sec_inc", 32'(lvPacked()), 32'h005911);
    applyStimulus(1'b1, 1'b0);
    nextCycle();

    // Invalid hour captured as-is, wraps to 00 on increment
    setCur(4'd2, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("invalid_capture", 32'(lvPacked()), 32'h250000);
    applyStimulus(1'b0, 1'b1);
    checkOutput("invalid_wrap", 32'(lvPacked()), 32'h000000);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    nextCycle();

    // Reset during SET_MIN
    setCur(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("pre_reset_value", 32'(lvPacked()), 32'h000100);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_field", 32'(edit_field), 32'd0);
    checkOutput("midreset_value", 32'(lvPacked()), 32'd0);
    checkOutput("midreset_load_en", 32'(load_value_enable), 32'd0);
    checkOutput("midreset_ce", 32'(count_enable), 32'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput($sformatf("post_reset_ce_c%0d", c), 32'(count_enable),
                  (c == 4) ? 32'd1 : 32'd0);
    end
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
